// File: rtl/f1d_pipe_if.sv
// Bus bundle for f1d_pipe: input stream (D/DV/DRDY), output stream (Q/QV/RDY),
// flush control and occupancy count. The pipeline uses the slave view.
interface f1d_pipe_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
);
   // Handshake: a word moves on a rising edge exactly when its valid and the
   // receiver's ready are both 1 (DV&DRDY in, QV&RDY out); DRDY never looks at DV.
   logic [WIDTH-1:0] D;
   logic             DV;
   logic             DRDY;
   logic             FLUSH;
   logic [WIDTH-1:0] Q;
   logic             QV;
   logic             RDY;
   logic [CW-1:0]    CNT;

   modport master (output D, DV, FLUSH, RDY, input DRDY, Q, QV, CNT);
   modport slave  (input D, DV, FLUSH, RDY, output DRDY, Q, QV, CNT);
endinterface

// File: rtl/f1d_pipe.sv
// WIDTH-bit, DEPTH-stage registered pipeline with valid/ready flow control,
// bubble collapsing, synchronous flush and a registered occupancy count.
module f1d_pipe #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic         CK,
   input  logic         RST,
   f1d_pipe_if.slave    bus
);
   logic [WIDTH-1:0] r_s [DEPTH];
   logic [DEPTH-1:0] r_v;
   logic [CW-1:0]    r_cnt;

   logic [DEPTH-1:0] w_go;
   logic             w_drdy;
   logic             w_accept;
   logic             w_out_xfer;

   // A stage moves when some stage ahead of it is empty, or every stage ahead
   // is full and the output drains; this unrolled form avoids a ripple through w_go.
   always_comb begin
      logic w_full_above;
      w_full_above = 1'b1;
      w_go         = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         w_go[i]      = r_v[i] & (~w_full_above | bus.RDY);
         w_full_above = w_full_above & r_v[i];
      end
   end

   assign w_drdy     = (~r_v[0] | w_go[0]) & ~bus.FLUSH & ~RST;
   assign w_accept   = bus.DV & w_drdy;
   assign w_out_xfer = r_v[DEPTH-1] & bus.RDY;

   always_ff @(posedge CK) begin
      if (RST) begin
         r_v   <= '0;
         r_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_s[i] <= '0;
         end
      end else if (bus.FLUSH) begin
         r_v   <= '0;
         r_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_s[0] <= bus.D;
            r_v[0] <= 1'b1;
         end else if (w_go[0]) begin
            r_v[0] <= 1'b0;
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (w_go[i-1]) begin
               r_s[i] <= r_s[i-1];
               r_v[i] <= 1'b1;
            end else if (w_go[i]) begin
               r_v[i] <= 1'b0;
            end
         end
         r_cnt <= r_cnt + CW'(w_accept) - CW'(w_out_xfer);
      end
   end

   assign bus.DRDY = w_drdy;
   assign bus.Q    = r_s[DEPTH-1];
   assign bus.QV   = r_v[DEPTH-1];
   assign bus.CNT  = r_cnt;
endmodule

// File: tb/tb_f1d_pipe.sv
// Bench for f1d_pipe: directed vector table, randomized run against a
// positional queue model plus an order scoreboard, and a DEPTH=1 instance.
module tb_f1d_pipe;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic CK;
   logic rst;
   logic rst1;
   int   total;
   int   bad;

   f1d_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
   f1d_pipe_if #(.WIDTH(WIDTH), .DEPTH(1))     bus1 ();

   f1d_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut  (.CK(CK), .RST(rst),  .bus(bus));
   f1d_pipe #(.WIDTH(WIDTH), .DEPTH(1))     dut1 (.CK(CK), .RST(rst1), .bus(bus1));

   initial CK = 1'b0;
   always #5 CK = ~CK;

   typedef struct {
      logic             rst;
      logic             dv;
      logic [WIDTH-1:0] d;
      logic             flush;
      logic             rdy;
      logic             drdy;
      logic             qv;
      logic [WIDTH-1:0] q;
      logic [2:0]       cnt;
   } vec_t;
   vec_t vecs[$];

   // Model: words in arrival order, each with the stage it occupies.
   typedef struct {
      logic [WIDTH-1:0] d;
      int               pos;
   } mw_t;
   mw_t              m_q[$];
   int               m_np[$];
   logic [WIDTH-1:0] m_qreg;
   logic [WIDTH-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   function automatic void add(input logic r, input logic dv, input logic [WIDTH-1:0] d,
                               input logic fl, input logic rdy, input logic drdy,
                               input logic qv, input logic [WIDTH-1:0] q, input logic [2:0] cnt);
      vec_t v;
      v.rst = r; v.dv = dv; v.d = d; v.flush = fl; v.rdy = rdy;
      v.drdy = drdy; v.qv = qv; v.q = q; v.cnt = cnt;
      vecs.push_back(v);
   endfunction

   // A word advances one stage when the slot ahead ends up free; leaving the
   // last stage means moving to DEPTH, allowed only when downstream is ready.
   task automatic model_plan(input logic rdy);
      int prev_new;
      m_np.delete();
      prev_new = rdy ? DEPTH + 1 : DEPTH;
      for (int k = 0; k < m_q.size(); k++) begin
         if (m_q[k].pos + 1 < prev_new) m_np.push_back(m_q[k].pos + 1);
         else                           m_np.push_back(m_q[k].pos);
         prev_new = m_np[k];
      end
   endtask

   function automatic logic model_drdy(input logic flush, input logic r);
      logic taken;
      taken = (m_q.size() > 0) && (m_np[m_np.size()-1] == 0);
      return !taken && !flush && !r;
   endfunction

   task automatic model_commit(input logic dv, input logic [WIDTH-1:0] d,
                               input logic flush, input logic r, input logic drdy);
      mw_t w;
      if (r) begin
         m_q.delete();
         m_qreg = '0;
      end else if (flush) begin
         m_q.delete();
      end else begin
         for (int k = 0; k < m_q.size(); k++) begin
            if (m_np[k] == DEPTH - 1 && m_q[k].pos != DEPTH - 1) m_qreg = m_q[k].d;
            m_q[k].pos = m_np[k];
         end
         if (m_q.size() > 0 && m_q[0].pos == DEPTH) void'(m_q.pop_front());
         if (dv && drdy) begin
            w.d = d;
            w.pos = 0;
            m_q.push_back(w);
         end
      end
   endtask

   task automatic drive(input logic r, input logic dv, input logic [WIDTH-1:0] d,
                        input logic fl, input logic rdy);
      rst       = r;
      bus.DV    = dv;
      bus.D     = d;
      bus.FLUSH = fl;
      bus.RDY   = rdy;
   endtask

   initial begin
      logic             r_rst, r_dv, r_fl, r_rdy, e_drdy, e_qv;
      logic [WIDTH-1:0] r_d;
      total = 0;
      bad   = 0;
      rst1  = 1'b1;
      bus1.D = '0; bus1.DV = 1'b0; bus1.FLUSH = 1'b0; bus1.RDY = 1'b0;
      drive(1'b1, 1'b0, '0, 1'b0, 1'b0);

      // Reset, streaming, stall with collapse
      add(1,1,16'hFFFF,0,1, 0, 0,16'h0000,0);
      add(1,1,16'hFFFF,0,1, 0, 0,16'h0000,0);
      add(0,0,16'h0000,0,1, 1, 0,16'h0000,0);
      add(0,1,16'h0001,0,1, 1, 0,16'h0000,1);
      add(0,1,16'h0002,0,1, 1, 0,16'h0000,2);
      add(0,1,16'h0003,0,1, 1, 0,16'h0000,3);
      add(0,1,16'h0004,0,1, 1, 1,16'h0001,4);
      add(0,1,16'h0005,0,1, 1, 1,16'h0002,4);
      add(0,1,16'h0006,0,1, 1, 1,16'h0003,4);
      add(0,0,16'h0000,0,1, 1, 1,16'h0004,3);
      add(0,0,16'h0000,0,1, 1, 1,16'h0005,2);
      add(0,0,16'h0000,0,1, 1, 1,16'h0006,1);
      add(0,0,16'h0000,0,1, 1, 0,16'h0006,0);
      add(0,1,16'hA5A5,0,0, 1, 0,16'h0006,1);
      add(0,0,16'h0000,0,0, 1, 0,16'h0006,1);
      add(0,1,16'h5A5A,0,0, 1, 0,16'h0006,2);
      add(0,0,16'h0000,0,0, 1, 1,16'hA5A5,2);
      add(0,0,16'h0000,0,0, 1, 1,16'hA5A5,2);
      add(0,1,16'h1111,0,0, 1, 1,16'hA5A5,3);
      add(0,1,16'h2222,0,0, 1, 1,16'hA5A5,4);
      add(0,1,16'h3333,0,0, 0, 1,16'hA5A5,4);
      add(0,0,16'h0000,0,1, 1, 1,16'h5A5A,3);
      add(0,0,16'h0000,0,1, 1, 1,16'h1111,2);
      add(0,0,16'h0000,0,1, 1, 1,16'h2222,1);
      add(0,0,16'h0000,0,1, 1, 0,16'h2222,0);
      // Fill under stall, then full with simultaneous in/out transfers
      for (int k = 0; k < 4; k++)
         add(0,1,16'h0100 + 16'(k),0,0, 1, (k == 3), (k == 3) ? 16'h0100 : 16'h2222, 3'(k + 1));
      for (int j = 0; j < 10; j++)
         add(0,1,16'h0104 + 16'(j),0,1, 1, 1,16'h0101 + 16'(j),4);
      // Flush mid-stall with DV high, then a fresh word B
      add(0,0,16'h0000,0,1, 1, 1,16'h010B,3);
      add(0,0,16'h0000,0,0, 1, 1,16'h010B,3);
      add(0,1,16'hBEEF,1,0, 0, 0,16'h010B,0);
      add(0,0,16'h0000,0,1, 1, 0,16'h010B,0);
      add(0,1,16'h0B0B,0,1, 1, 0,16'h010B,1);
      add(0,0,16'h0000,0,1, 1, 0,16'h010B,1);
      add(0,0,16'h0000,0,1, 1, 0,16'h010B,1);
      add(0,0,16'h0000,0,1, 1, 1,16'h0B0B,1);
      add(0,0,16'h0000,0,1, 1, 0,16'h0B0B,0);

      @(negedge CK);
      for (int n = 0; n < vecs.size(); n++) begin
         drive(vecs[n].rst, vecs[n].dv, vecs[n].d, vecs[n].flush, vecs[n].rdy);
         #1;
         check($sformatf("vec%0d_drdy", n), 32'(bus.DRDY), 32'(vecs[n].drdy));
         @(negedge CK);
         check($sformatf("vec%0d_qv", n),  32'(bus.QV),  32'(vecs[n].qv));
         check($sformatf("vec%0d_q", n),   32'(bus.Q),   32'(vecs[n].q));
         check($sformatf("vec%0d_cnt", n), 32'(bus.CNT), 32'(vecs[n].cnt));
      end

      // Randomized run; the first cycle is a reset to align the model
      for (int c = 0; c < 1500; c++) begin
         r_rst = (c == 0) || ($urandom_range(0, 199) == 0);
         r_fl  = ($urandom_range(0, 19) == 0);
         r_dv  = ($urandom_range(0, 2) != 0);
         r_rdy = ($urandom_range(0, 3) != 0);
         r_d   = WIDTH'($urandom);
         drive(r_rst, r_dv, r_d, r_fl, r_rdy);
         #1;
         model_plan(r_rdy);
         e_drdy = model_drdy(r_fl, r_rst);
         check("rand_drdy", 32'(bus.DRDY), 32'(e_drdy));
         if (!r_rst && bus.QV && r_rdy) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rand_order t=%0t actual=%0h required=none", $time, bus.Q);
            end else begin
               check("rand_order", 32'(bus.Q), 32'(exp_q.pop_front()));
            end
         end
         if (r_rst || r_fl)      exp_q.delete();
         else if (r_dv && e_drdy) exp_q.push_back(r_d);
         model_commit(r_dv, r_d, r_fl, r_rst, e_drdy);
         @(negedge CK);
         e_qv = (m_q.size() > 0) && (m_q[0].pos == DEPTH - 1);
         check("rand_qv",  32'(bus.QV),  32'(e_qv));
         check("rand_q",   32'(bus.Q),   32'(m_qreg));
         check("rand_cnt", 32'(bus.CNT), 32'(m_q.size()));
      end

      // DEPTH=1 instance: plain register with backpressure
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("d1_reset_qv",  32'(bus1.QV),  32'd0);
      check("d1_reset_q",   32'(bus1.Q),   32'h0);
      check("d1_reset_cnt", 32'(bus1.CNT), 32'd0);
      rst1 = 1'b0; bus1.DV = 1'b1; bus1.D = 16'h1234; bus1.RDY = 1'b1;
      #1;
      check("d1_drdy_empty", 32'(bus1.DRDY), 32'd1);
      @(negedge CK);
      check("d1_q",   32'(bus1.Q),   32'h1234);
      check("d1_qv",  32'(bus1.QV),  32'd1);
      check("d1_cnt", 32'(bus1.CNT), 32'd1);
      bus1.D = 16'h5678; bus1.RDY = 1'b0;
      #1;
      check("d1_drdy_stall", 32'(bus1.DRDY), 32'd0);
      @(negedge CK);
      check("d1_q_hold", 32'(bus1.Q), 32'h1234);
      bus1.RDY = 1'b1;
      #1;
      check("d1_drdy_pass", 32'(bus1.DRDY), 32'd1);
      @(negedge CK);
      check("d1_q_next", 32'(bus1.Q), 32'h5678);
      bus1.DV = 1'b0;
      @(negedge CK);
      check("d1_qv_drain",  32'(bus1.QV),  32'd0);
      check("d1_cnt_drain", 32'(bus1.CNT), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
